// File: rtl/cache_line_refill_pkg.sv
// Shared constants, state encoding and address helpers for the
// instruction-cache line refill engine.
package cache_line_refill_pkg;

  localparam int number_of_sets         = 4;
  localparam int log_of_number_of_sets  = 2;
  localparam int bits_for_offset        = 6;
  localparam int single_lane_size       = 8 * (2 ** bits_for_offset);
  localparam int mem_data_width         = 32;
  localparam int address_width          = 32;
  localparam int beats                  = single_lane_size / mem_data_width;
  localparam int beat_count_width       = $clog2(beats) + 1;

  localparam logic [address_width-1:0] line_align_mask =
    {address_width{1'b1}} << bits_for_offset;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  function automatic logic [address_width-1:0] align_line(
    input logic [address_width-1:0] addr
  );
    return addr & line_align_mask;
  endfunction

  // Round-robin victim selection, wrapping at the last way.
  function automatic logic [log_of_number_of_sets-1:0] next_victim(
    input logic [log_of_number_of_sets-1:0] victim
  );
    if (victim == log_of_number_of_sets'(number_of_sets - 1)) begin
      return '0;
    end else begin
      return victim + log_of_number_of_sets'(1);
    end
  endfunction

endpackage

// File: rtl/cache_line_refill_line_beat_assembler.sv
// Collects burst beats into one cache line, beat k at word k, and flags the
// cycle in which the final beat is written.
module cache_line_refill_line_beat_assembler #(
  parameter int data_width  = 32,
  parameter int beats       = 16,
  parameter int count_width = $clog2(beats) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         capture,
  input  logic                         beat_valid,
  input  logic [data_width-1:0]        beat_data,
  output logic [data_width*beats-1:0]  line_data,
  output logic                         last_beat
);

  logic [count_width-1:0] beat_count_r;
  logic                   write_s;

  // Beats are only accepted while the owning FSM is receiving.
  always_comb begin
    write_s   = 1'b0;
    last_beat = 1'b0;
    if (capture && beat_valid) begin
      write_s   = 1'b1;
      last_beat = (beat_count_r == count_width'(beats - 1));
    end else begin
      write_s   = 1'b0;
      last_beat = 1'b0;
    end
  end

  // Beat index: advances per accepted beat, cleared once the line is handed off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count_r <= '0;
    end else if (clear) begin
      beat_count_r <= '0;
    end else if (write_s) begin
      beat_count_r <= beat_count_r + count_width'(1);
    end
  end

  // Line register: each beat lands in its own word slot, others hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_data <= '0;
    end else begin
      for (int i = 0; i < beats; i++) begin
        if (write_s && (beat_count_r == count_width'(i))) begin
          line_data[i*data_width +: data_width] <= beat_data;
        end
      end
    end
  end

endmodule

// File: rtl/cache_line_refill.sv
// Instruction-cache miss refill: one Avalon-MM burst per line, then a
// single-cycle fill pulse carrying line, aligned address and victim way.
module cache_line_refill
  import cache_line_refill_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              miss_valid,
  input  logic [address_width-1:0]          miss_address,
  output logic                              miss_ready,
  output logic [address_width-1:0]          avm_address,
  output logic                              avm_read,
  output logic [beat_count_width-1:0]       avm_burstcount,
  input  logic                              avm_waitrequest,
  input  logic [mem_data_width-1:0]         avm_readdata,
  input  logic                              avm_readdatavalid,
  output logic                              fill_valid,
  output logic [single_lane_size-1:0]       fill_data,
  output logic [address_width-1:0]          fill_address,
  output logic [log_of_number_of_sets-1:0]  fill_pos
);

  refill_state_t                     state_r;
  logic [log_of_number_of_sets-1:0]  victim_r;
  logic                              beat_capture_s;
  logic                              beat_clear_s;
  logic                              last_beat_s;

  assign avm_burstcount = beat_count_width'(beats);

  // Assembler control decoded from the current state.
  always_comb begin
    beat_capture_s = 1'b0;
    beat_clear_s   = 1'b0;
    if (state_r == RECV) begin
      beat_capture_s = 1'b1;
    end else begin
      beat_capture_s = 1'b0;
    end
    if (state_r == DONE) begin
      beat_clear_s = 1'b1;
    end else begin
      beat_clear_s = 1'b0;
    end
  end

  cache_line_refill_line_beat_assembler #(
    .data_width  (mem_data_width),
    .beats       (beats),
    .count_width (beat_count_width)
  ) u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (beat_clear_s),
    .capture    (beat_capture_s),
    .beat_valid (avm_readdatavalid),
    .beat_data  (avm_readdata),
    .line_data  (fill_data),
    .last_beat  (last_beat_s)
  );

  // Refill FSM with registered handshake, command and fill outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      miss_ready   <= 1'b1;
      avm_read     <= 1'b0;
      avm_address  <= '0;
      fill_valid   <= 1'b0;
      fill_address <= '0;
      fill_pos     <= '0;
      victim_r     <= '0;
    end else begin
      fill_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (miss_valid) begin
            avm_address <= align_line(miss_address);
            avm_read    <= 1'b1;
            miss_ready  <= 1'b0;
            state_r     <= REQ;
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state_r  <= RECV;
          end
        end
        RECV: begin
          // The last beat is written into the line on this same edge.
          if (last_beat_s) begin
            fill_valid   <= 1'b1;
            fill_address <= avm_address;
            fill_pos     <= victim_r;
            state_r      <= DONE;
          end
        end
        DONE: begin
          victim_r   <= next_victim(victim_r);
          miss_ready <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          avm_read   <= 1'b0;
          miss_ready <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
